// File: rtl/tt_um_i2c_to_spi.sv
// tt_um_i2c_to_spi: I2C slave (write-only by default) bridged to an SPI
// mode-0 master. Each byte written to the configured 7-bit address is
// re-sent MSB first on MOSI; CS_n spans the whole addressed transaction.
// Optional feature macro: I2C_READ_EN -- enables I2C reads that return the
// byte last captured from MISO. Each master ACK launches a 0x00 dummy SPI
// transfer so that a later read byte holds fresh MISO data.
`timescale 1ns/1ps

module tt_um_i2c_to_spi (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WRITE, S_WRITE_ACK, S_READ, S_READ_ACK
  } state_t;

  // ---------------- input synchronizers and bus conditions ----------------
  logic scl_meta, scl_s, scl_d;
  logic sda_meta, sda_s, sda_d;

  // Two-stage synchronizers plus one delayed copy for edge detection; the
  // idle bus is high, so reset to 1 to avoid a phantom edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {scl_meta, scl_s, scl_d} <= 3'b111;
      {sda_meta, sda_s, sda_d} <= 3'b111;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the previous
      // value of the stage before it; blocking ones would collapse the chain.
      scl_meta <= ui_in[0];
      scl_s    <= scl_meta;
      scl_d    <= scl_s;
      sda_meta <= uio_in[0];
      sda_s    <= sda_meta;
      sda_d    <= sda_s;
    end
  end

  logic scl_rise, scl_fall, start_c, stop_c;
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  assign start_c  = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_c   = scl_s & scl_d & ~sda_d & sda_s;

  // ---------------- I2C FSM registers and their next values ----------------
  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       sda_oe_q, sda_oe_d;
  logic       ack_ok_q, ack_ok_d;
  logic       ack_ph_q, ack_ph_d;   // second half of an ACK bit / master ACKed
  logic       rw_q, rw_d;
  logic       hold_wr;
  logic [7:0] hold_wdata;
  logic       cs_assert;

  // Holding register and SPI engine state shared with the FSM
  logic       hold_full;
  logic [7:0] hold_data;
  logic       spi_busy, spi_load;
  logic [4:0] spi_phase;
  logic [7:0] spi_tx;
  logic [7:0] rx_reg;
  logic       cs_n_q, stop_pend, stop_cnt;

  // I2C state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      sda_oe_q  <= 1'b0;
      ack_ok_q  <= 1'b0;
      ack_ph_q  <= 1'b0;
      rw_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      sda_oe_q  <= sda_oe_d;
      ack_ok_q  <= ack_ok_d;
      ack_ph_q  <= ack_ph_d;
      rw_q      <= rw_d;
    end
  end

  // I2C next-state, SDA drive and holding-register write strobe
  always_comb begin
    // NOTE: every variable gets a default before any branch; a path that
    // leaves one unassigned would infer a latch.
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    sda_oe_d   = sda_oe_q;
    ack_ok_d   = ack_ok_q;
    ack_ph_d   = ack_ph_q;
    rw_d       = rw_q;
    hold_wr    = 1'b0;
    hold_wdata = {shift_q[6:0], sda_s};
    cs_assert  = 1'b0;
    if (stop_c) begin
      state_d  = S_IDLE;
      sda_oe_d = 1'b0;
    end else if (start_c) begin
      state_d   = S_ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      ack_ph_d  = 1'b0;
    end else begin
      case (state_q)
        S_ADDR: if (scl_rise) begin
          shift_d   = {shift_q[6:0], sda_s};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = '0;
            ack_ph_d  = 1'b0;
            rw_d      = sda_s;
`ifdef I2C_READ_EN
            state_d = (shift_q[6:0] == ui_in[7:1]) ? S_ADDR_ACK : S_IDLE;
`else
            state_d = (shift_q[6:0] == ui_in[7:1] && !sda_s) ? S_ADDR_ACK : S_IDLE;
`endif
          end
        end
        S_ADDR_ACK: if (scl_fall) begin
          if (!ack_ph_q) begin
            ack_ph_d  = 1'b1;
            sda_oe_d  = 1'b1;
            cs_assert = 1'b1;
          end else begin
            ack_ph_d  = 1'b0;
            bit_cnt_d = '0;
            state_d   = S_WRITE;
            sda_oe_d  = 1'b0;
`ifdef I2C_READ_EN
            if (rw_q) begin
              state_d  = S_READ;
              shift_d  = rx_reg;
              sda_oe_d = ~rx_reg[7];
            end
`endif
          end
        end
        S_WRITE: if (scl_rise) begin
          shift_d   = {shift_q[6:0], sda_s};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            hold_wr   = ~hold_full;
            ack_ok_d  = ~hold_full;
            bit_cnt_d = '0;
            ack_ph_d  = 1'b0;
            state_d   = S_WRITE_ACK;
          end
        end
        S_WRITE_ACK: if (scl_fall) begin
          if (!ack_ph_q) begin
            ack_ph_d = 1'b1;
            sda_oe_d = ack_ok_q;
          end else begin
            ack_ph_d = 1'b0;
            sda_oe_d = 1'b0;
            state_d  = S_WRITE;
          end
        end
`ifdef I2C_READ_EN
        S_READ: begin
          if (scl_rise) bit_cnt_d = bit_cnt_q + 4'd1;
          else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              ack_ph_d  = 1'b0;
              state_d   = S_READ_ACK;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        S_READ_ACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              ack_ph_d   = 1'b1;
              hold_wr    = ~hold_full;
              hold_wdata = 8'h00;
            end else begin
              state_d = S_IDLE;
            end
          end else if (scl_fall && ack_ph_q) begin
            ack_ph_d  = 1'b0;
            bit_cnt_d = '0;
            shift_d   = rx_reg;
            sda_oe_d  = ~rx_reg[7];
            state_d   = S_READ;
          end
        end
`endif
        default: state_d = state_q;
      endcase
    end
  end

  // ---------------- holding register ----------------
  assign spi_load = hold_full & ~spi_busy;

  // One-byte buffer between the I2C side and the SPI engine
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full <= 1'b0;
      // NOTE: the data byte is reset too, although only hold_full gates its
      // use, so nothing downstream ever sees an X after power-up.
      hold_data <= '0;
    end else if (hold_wr) begin
      hold_full <= 1'b1;
      hold_data <= hold_wdata;
    end else if (spi_load) begin
      hold_full <= 1'b0;
    end
  end

  // ---------------- SPI engine ----------------
  // Mode 0, 4 clk per bit: SCLK high in phases 2-3, MOSI shifts at phase 3->0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_busy  <= 1'b0;
      spi_phase <= '0;
      spi_tx    <= '0;
    end else if (spi_load) begin
      spi_busy  <= 1'b1;
      spi_phase <= '0;
      spi_tx    <= hold_data;
    end else if (spi_busy) begin
      spi_phase <= spi_phase + 5'd1;
      if (spi_phase[1:0] == 2'd3) spi_tx <= {spi_tx[6:0], 1'b0};
      if (spi_phase == 5'd31) spi_busy <= 1'b0;
    end
  end

`ifdef I2C_READ_EN
  logic [7:0] rx_sh;

  // MISO sampled as SCLK rises; committed to rx_reg only when a byte ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sh  <= '0;
      rx_reg <= '0;
    end else if (spi_busy) begin
      if (spi_phase[1:0] == 2'd1) rx_sh <= {rx_sh[6:0], uio_in[1]};
      if (spi_phase == 5'd31) rx_reg <= rx_sh;
    end
  end
`else
  assign rx_reg = 8'h00;
`endif

  // CS_n: low from the address ACK, high 2 clk after STOP once SPI drains
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_n_q    <= 1'b1;
      stop_pend <= 1'b0;
      stop_cnt  <= 1'b0;
    end else if (cs_assert) begin
      cs_n_q    <= 1'b0;
      stop_pend <= 1'b0;
    end else if (stop_c && !cs_n_q) begin
      stop_pend <= 1'b1;
      stop_cnt  <= 1'b0;
    end else if (stop_pend && !spi_busy && !hold_full) begin
      if (stop_cnt) begin
        cs_n_q    <= 1'b1;
        stop_pend <= 1'b0;
      end else begin
        stop_cnt <= 1'b1;
      end
    end
  end

  // ---------------- outputs ----------------
  logic i2c_active;
  assign i2c_active = state_q inside {S_ADDR_ACK, S_WRITE, S_WRITE_ACK, S_READ, S_READ_ACK};

  assign uo_out  = {3'b000, i2c_active, spi_busy, cs_n_q, spi_tx[7], spi_busy & spi_phase[1]};
  assign uio_out = 8'h00;
  assign uio_oe  = {7'b0, sda_oe_q};

`ifdef I2C_READ_EN
  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in[7:2], rx_reg == 8'h00 && 1'b0};
`else
  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in[7:1], rw_q, rx_reg};
`endif

endmodule

// File: tb/tb_tt_um_i2c_to_spi.sv
// Directed bench for tt_um_i2c_to_spi: a bit-banged I2C master drives the
// bridge while monitors collect SPI bytes into a scoreboard and time
// spi_busy. Expected SPI bytes are queued as the master writes them.
`timescale 1ns/1ps

module tb_tt_um_i2c_to_spi;

  localparam int Q = 80;  // quarter SCL period in ns (SCL period = 32 clk)

  logic       clk = 1'b0;
  logic       rst_n, ena, scl, sda_m, miso, sda_line;
  logic [6:0] addr_cfg;
  logic [7:0] ui_in, uo_out, uio_in, uio_out, uio_oe;

  always #5 clk = ~clk;

  assign sda_line = sda_m & ~uio_oe[0];
  assign ui_in    = {addr_cfg, scl};
  assign uio_in   = {6'b0, miso, sda_line};

  tt_um_i2c_to_spi dut (
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe),
    .ena    (ena),
    .clk    (clk),
    .rst_n  (rst_n)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard of bytes expected on MOSI
  logic [7:0] exp_q[$];
  int         spi_bytes = 0;
  int         sclk_rises = 0;
  int         mbits = 0;
  logic [7:0] mbyte = 8'h00;

  // MOSI collector: one bit per SCLK rise, CS_n must be low throughout
  always @(posedge uo_out[0] or negedge rst_n) begin
    if (!rst_n) begin
      mbits = 0;
    end else begin
      #1;
      sclk_rises++;
      check("cs_low_at_sclk", 32'(uo_out[2]), 32'd0);
      mbyte = {mbyte[6:0], uo_out[1]};
      mbits++;
      if (mbits == 8) begin
        mbits = 0;
        spi_bytes++;
        if (exp_q.size() == 0) check("spi_byte_expected", 32'(exp_q.size()), 32'd1);
        else check("spi_byte", 32'(mbyte), 32'(exp_q.pop_front()));
      end
    end
  end

  // spi_busy pulse length per byte
  int busy_cnt = 0;
  always @(negedge clk) begin
    if (!rst_n) busy_cnt = 0;
    else if (uo_out[3] === 1'b1) busy_cnt++;
    else if (busy_cnt != 0) begin
      check("busy_len", 32'(busy_cnt), 32'd32);
      busy_cnt = 0;
    end
  end

  // Any SDA pull-down since the flag was last cleared
  logic oe_seen = 1'b0;
  always @(posedge clk) if (uio_oe[0] === 1'b1) oe_seen = 1'b1;

  // SPI slave model: shifts 0xC3 out MSB first, advancing on SCLK falls
  logic [2:0] miso_idx = 3'd0;
  logic [7:0] miso_pat = 8'hC3;
  always @(negedge uo_out[0] or posedge uo_out[2]) begin
    if (uo_out[2] === 1'b1) miso_idx = 3'd0;
    else miso_idx = miso_idx + 3'd1;
  end
  assign miso = miso_pat[3'd7 - miso_idx];

  // ---------------- I2C master tasks ----------------
  task automatic i2c_start();
    sda_m = 1'b1; #(Q);
    scl   = 1'b1; #(Q);
    sda_m = 1'b0; #(Q);
    scl   = 1'b0; #(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #(Q);
    scl   = 1'b1; #(Q);
    sda_m = 1'b1; #(Q);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; #(Q);
    scl   = 1'b1; #(2*Q);
    scl   = 1'b0; #(Q);
  endtask

  task automatic i2c_write_byte(input logic [7:0] data, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(data[i]);
    sda_m = 1'b1; #(Q);
    scl   = 1'b1; #(Q);
    ack   = ~sda_line; #(Q);
    scl   = 1'b0; #(Q);
  endtask

  task automatic i2c_read_byte(input logic master_ack, output logic [7:0] data);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      #(Q); scl = 1'b1;
      #(Q); data[i] = sda_line;
      #(Q); scl = 1'b0;
      #(Q);
    end
    sda_m = ~master_ack; #(Q);
    scl   = 1'b1; #(2*Q);
    scl   = 1'b0; #(Q);
    sda_m = 1'b1;
  endtask

  task automatic wait_cs_high(input string tag);
    int n = 0;
    while (uo_out[2] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(uo_out[2]), 32'd1);
  endtask

  // Absolute time bound on the whole run
  initial begin
    #(500000);
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic       ack;
    logic [7:0] rd;
    logic [7:0] abort_byte;
    int         rises0;
    int         n;

    rst_n = 1'b0; ena = 1'b1; scl = 1'b1; sda_m = 1'b1; addr_cfg = 7'h50;
    repeat (3) @(negedge clk);
    check("rst_uo_out", 32'(uo_out), 32'h04);
    check("rst_uio_oe", 32'(uio_oe), 32'h00);
    check("rst_uio_out", 32'(uio_out), 32'h00);
    rst_n = 1'b1;
    miso_idx = 3'd0;
    repeat (5) @(negedge clk);

    // Two-byte write to the matching address
    i2c_start();
    i2c_write_byte({7'h50, 1'b0}, ack);
    check("addr_ack", 32'(ack), 32'd1);
    check("cs_low_after_ack", 32'(uo_out[2]), 32'd0);
    check("i2c_active", 32'(uo_out[4]), 32'd1);
    exp_q.push_back(8'hA5);
    i2c_write_byte(8'hA5, ack);
    check("data0_ack", 32'(ack), 32'd1);
    exp_q.push_back(8'h3C);
    i2c_write_byte(8'h3C, ack);
    check("data1_ack", 32'(ack), 32'd1);
    i2c_stop();
    wait_cs_high("cs_high_after_stop");
    check("spi_bytes_written", 32'(spi_bytes), 32'd2);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("idle_after_stop", 32'(uo_out), 32'h04);

    // Non-matching address: no SDA drive, no SPI activity
    repeat (10) @(negedge clk);
    rises0 = sclk_rises;
    oe_seen = 1'b0;
    i2c_start();
    i2c_write_byte({7'h51, 1'b0}, ack);
    check("nomatch_addr_nack", 32'(ack), 32'd0);
    i2c_write_byte(8'hFF, ack);
    check("nomatch_data_nack", 32'(ack), 32'd0);
    check("nomatch_cs_high", 32'(uo_out[2]), 32'd1);
    i2c_stop();
    repeat (10) @(negedge clk);
    check("nomatch_no_sda", 32'(oe_seen), 32'd0);
    check("nomatch_no_sclk", 32'(sclk_rises), 32'(rises0));

`ifdef I2C_READ_EN
    // Write one byte (captures 0xC3 from MISO), then repeated-START read
    i2c_start();
    i2c_write_byte({7'h50, 1'b0}, ack);
    check("rd_waddr_ack", 32'(ack), 32'd1);
    exp_q.push_back(8'h11);
    i2c_write_byte(8'h11, ack);
    check("rd_wdata_ack", 32'(ack), 32'd1);
    i2c_start();
    check("cs_low_rep_start", 32'(uo_out[2]), 32'd0);
    i2c_write_byte({7'h50, 1'b1}, ack);
    check("rd_raddr_ack", 32'(ack), 32'd1);
    check("cs_low_rd_addr", 32'(uo_out[2]), 32'd0);
    i2c_read_byte(1'b0, rd);
    check("read_byte", 32'(rd), 32'hC3);
    i2c_stop();
    wait_cs_high("cs_high_after_read");
    check("rd_queue_drained", 32'(exp_q.size()), 32'd0);
`else
    // Read address is refused when reads are not built in
    i2c_start();
    i2c_write_byte({7'h50, 1'b1}, ack);
    check("read_addr_nack", 32'(ack), 32'd0);
    check("read_uo_out", 32'(uo_out), 32'h04);
    i2c_stop();
    repeat (10) @(negedge clk);
    check("read_uo_out_after_stop", 32'(uo_out), 32'h04);
`endif

    // Reset in the middle of an SPI byte while the data ACK is being driven
    repeat (10) @(negedge clk);
    i2c_start();
    i2c_write_byte({7'h50, 1'b0}, ack);
    check("abort_addr_ack", 32'(ack), 32'd1);
    abort_byte = 8'h5A;
    for (int i = 7; i >= 0; i--) write_bit(abort_byte[i]);
    n = 0;
    while (uo_out[3] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("busy_before_reset", 32'(uo_out[3]), 32'd1);
    check("ack_drive_before_reset", 32'(uio_oe[0]), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("abort_uo_out", 32'(uo_out), 32'h04);
    check("abort_sda_released", 32'(uio_oe), 32'h00);
    sda_m = 1'b0; scl = 1'b1; #(Q);
    sda_m = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_reset_idle", 32'(uo_out), 32'h04);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
